intersection_controller: RTL and testbench

- Parametrised, demand-actuated controller for an N-approach intersection.
- Each approach has protected-left, through and pedestrian phases.
- Adds min/max green extension, latched pedestrian requests, a flashing fault mode and per-approach red-light violation counters.
- Replaces the fixed 4-way light, pedestrian and red-light assembly as the single top-level timing block of the stoplight design.

---
 rtl/intersection_pkg.sv | 62 ++++++
 rtl/violation_monitor.sv | 49 ++++
 rtl/intersection_controller.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_intersection_controller.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intersection_pkg.sv
`default_nettype none
// ============================================================================
// Module      : intersection_pkg
// Description : Shared light/pedestrian encodings, FSM state codes and the
//               cyclic next-demand priority function for the intersection
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
package intersection_pkg;

    // Largest supported approach count; also the width of scan vectors.
    localparam int MAX_APPR = 8;

    // Vehicle light encoding (through and left heads).
    localparam logic [1:0] c_light_red    = 2'b00;
    localparam logic [1:0] c_light_yellow = 2'b01;
    localparam logic [1:0] c_light_green  = 2'b10;
    localparam logic [1:0] c_light_dark   = 2'b11;

    // Pedestrian head encoding.
    localparam logic [1:0] c_ped_dont_walk  = 2'b00;
    localparam logic [1:0] c_ped_walk       = 2'b10;
    localparam logic [1:0] c_ped_flash_dont = 2'b01;

    // Controller phases; the codes are visible on the state output.
    typedef enum logic [2:0] {
        ST_ALL_RED     = 3'd0,
        ST_LEFT_GREEN  = 3'd1,
        ST_LEFT_YELLOW = 3'd2,
        ST_THRU_GREEN  = 3'd3,
        ST_THRU_YELLOW = 3'd4,
        ST_FLASH       = 3'd5
    } state_t;

    // Returns {found, index} of the first set bit of demand, scanning
    // cyclically start, start+1, ... over num approaches (start < num).
    function automatic logic [3:0] next_demand(
        input logic [MAX_APPR-1:0] demand,
        input logic [2:0]          start,
        input logic [3:0]          num
    );
        logic       found;
        logic [2:0] pick;
        logic [3:0] pos;
        found = 1'b0;
        pick  = 3'd0;
        // Walk backwards so the earliest position in scan order wins.
        for (int k = MAX_APPR - 1; k >= 0; k--) begin
            pos = {1'b0, start} + 4'(k);
            if (pos >= num) begin
                pos = pos - num;
            end
            if ((4'(k) < num) && demand[pos[2:0]]) begin
                found = 1'b1;
                pick  = pos[2:0];
            end
        end
        return {found, pick};
    endfunction

endpackage
`default_nettype wire

// File: rtl/violation_monitor.sv
`default_nettype none
// ============================================================================
// Module      : violation_monitor
// Description : Red-light violation detector for one approach. Produces a
//               registered one-cycle pulse and a saturating event counter.
// Revision    : 1.0 - initial release
// ============================================================================
module violation_monitor
    import intersection_pkg::*;
#(
    parameter int VC_W = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_en,
    input  logic [1:0]      i_thru_light,
    input  logic [1:0]      i_left_light,
    input  logic            i_leaving,
    input  logic            i_leaving_left,
    output logic            o_violation,
    output logic [VC_W-1:0] o_count
);

    logic            w_hit;
    logic            r_violation;
    logic [VC_W-1:0] r_count;

    // A through and a left crossing in the same cycle collapse to one event.
    assign w_hit = i_en && ((i_leaving      && (i_thru_light == c_light_red)) ||
                            (i_leaving_left && (i_left_light == c_light_red)));

    // Pulse register and saturating counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_violation <= 1'b0;
            r_count     <= '0;
        end else begin
            r_violation <= w_hit;
            if (w_hit && (r_count != {VC_W{1'b1}})) begin
                r_count <= r_count + VC_W'(1);
            end
        end
    end

    assign o_violation = r_violation;
    assign o_count     = r_count;

endmodule
`default_nettype wire

// File: rtl/intersection_controller.sv
`default_nettype none
// ============================================================================
// Module      : intersection_controller
// Description : Demand-actuated N-approach intersection controller with
//               protected-left, through and pedestrian phases, min/max green
//               extension, flashing fault mode and red-light violation
//               counters. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module intersection_controller
    import intersection_pkg::*;
#(
    parameter int NUM_APPR   = 4,
    parameter int TMR_W      = 8,
    parameter int GREEN_MIN  = 10,
    parameter int GREEN_MAX  = 40,
    parameter int LEFT_T     = 6,
    parameter int YELLOW_T   = 4,
    parameter int ALLRED_T   = 2,
    parameter int PED_WALK_T = 6,
    parameter int FLASH_T    = 8,
    parameter int VC_W       = 4
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic                     flash_req,
    input  logic [NUM_APPR-1:0]      presence,
    input  logic [NUM_APPR-1:0]      left_presence,
    input  logic [NUM_APPR-1:0]      ped_req,
    input  logic [NUM_APPR-1:0]      leaving,
    input  logic [NUM_APPR-1:0]      leaving_left,
    output logic [2*NUM_APPR-1:0]    thru_light,
    output logic [2*NUM_APPR-1:0]    left_light,
    output logic [2*NUM_APPR-1:0]    ped_light,
    output logic [2:0]               state,
    output logic [2:0]               active_appr,
    output logic [NUM_APPR-1:0]      violation,
    output logic [VC_W*NUM_APPR-1:0] viol_count
);

    // Reject illegal parameter combinations at elaboration.
    if (PED_WALK_T > GREEN_MIN) begin : g_bad_ped_walk
        $error("PED_WALK_T must not exceed GREEN_MIN");
    end
    if ((NUM_APPR < 2) || (NUM_APPR > MAX_APPR)) begin : g_bad_num_appr
        $error("NUM_APPR must be in 2..8");
    end

    localparam logic [TMR_W-1:0] c_allred_last = TMR_W'(ALLRED_T - 1);
    localparam logic [TMR_W-1:0] c_left_last   = TMR_W'(LEFT_T - 1);
    localparam logic [TMR_W-1:0] c_yellow_last = TMR_W'(YELLOW_T - 1);
    localparam logic [TMR_W-1:0] c_gmin_last   = TMR_W'(GREEN_MIN - 1);
    localparam logic [TMR_W-1:0] c_gmax_last   = TMR_W'(GREEN_MAX - 1);
    localparam logic [TMR_W-1:0] c_walk_len    = TMR_W'(PED_WALK_T);
    localparam logic [TMR_W-1:0] c_flash_last  = TMR_W'(FLASH_T - 1);

    // State registers
    state_t              r_state;
    logic [TMR_W-1:0]    r_timer;
    logic [2:0]          r_active;
    logic                r_scan0;
    logic                r_walk;
    logic [TMR_W-1:0]    r_fcnt;
    logic                r_fyel;
    logic [NUM_APPR-1:0] r_latch;

    // Registered outputs
    logic [2*NUM_APPR-1:0] r_thru;
    logic [2*NUM_APPR-1:0] r_left;
    logic [2*NUM_APPR-1:0] r_ped;

    // Next-state values
    state_t              w_state_nx;
    logic [TMR_W-1:0]    w_timer_nx;
    logic [TMR_W-1:0]    w_timer_inc;
    logic [2:0]          w_active_nx;
    logic                w_scan0_nx;
    logic                w_walk_nx;
    logic [TMR_W-1:0]    w_fcnt_nx;
    logic                w_fyel_nx;
    logic [NUM_APPR-1:0] w_latch_nx;
    logic                w_enter_green;

    // Demand scan
    logic [NUM_APPR-1:0] w_demand;
    logic [2:0]          w_scan_start;
    logic [3:0]          w_pick;
    logic [NUM_APPR-1:0] w_sel_pick;
    logic [NUM_APPR-1:0] w_sel_act;
    logic [NUM_APPR-1:0] w_sel_nx;
    logic                w_pick_left;
    logic                w_act_present;

    // Next-cycle output images
    logic [2*NUM_APPR-1:0] w_thru_nx;
    logic [2*NUM_APPR-1:0] w_left_nx;
    logic [2*NUM_APPR-1:0] w_ped_nx;
    logic                  w_viol_en;

    assign w_demand     = presence | left_presence | r_latch;
    assign w_scan_start = r_scan0                          ? 3'd0 :
                          (r_active == 3'(NUM_APPR - 1))   ? 3'd0 :
                                                             r_active + 3'd1;
    assign w_pick       = next_demand(MAX_APPR'(w_demand), w_scan_start, 4'(NUM_APPR));
    assign w_timer_inc  = (r_timer == {TMR_W{1'b1}}) ? r_timer : r_timer + TMR_W'(1);

    // One-hot approach selects, so per-approach inputs are never bit-indexed.
    always_comb begin
        w_sel_pick = '0;
        w_sel_act  = '0;
        for (int i = 0; i < NUM_APPR; i++) begin
            w_sel_pick[i] = (w_pick[2:0] == 3'(i));
            w_sel_act[i]  = (r_active == 3'(i));
        end
    end

    assign w_pick_left   = |(left_presence & w_sel_pick);
    assign w_act_present = |(presence & w_sel_act);

    // Phase sequencing: next state, phase timer, served approach, flash toggle.
    always_comb begin
        w_state_nx  = r_state;
        w_timer_nx  = w_timer_inc;
        w_active_nx = r_active;
        w_scan0_nx  = r_scan0;
        w_fcnt_nx   = '0;
        w_fyel_nx   = 1'b1;
        if (flash_req) begin
            if (r_state != ST_FLASH) begin
                w_state_nx = ST_FLASH;
                w_timer_nx = '0;
            end else if (r_fcnt == c_flash_last) begin
                w_fcnt_nx = '0;
                w_fyel_nx = ~r_fyel;
            end else begin
                w_fcnt_nx = r_fcnt + TMR_W'(1);
                w_fyel_nx = r_fyel;
            end
        end else begin
            case (r_state)
                ST_ALL_RED: begin
                    if ((r_timer >= c_allred_last) && w_pick[3]) begin
                        w_active_nx = w_pick[2:0];
                        w_scan0_nx  = 1'b0;
                        w_timer_nx  = '0;
                        w_state_nx  = w_pick_left ? ST_LEFT_GREEN : ST_THRU_GREEN;
                    end
                end
                ST_LEFT_GREEN: begin
                    if (r_timer == c_left_last) begin
                        w_state_nx = ST_LEFT_YELLOW;
                        w_timer_nx = '0;
                    end
                end
                ST_LEFT_YELLOW: begin
                    if (r_timer == c_yellow_last) begin
                        w_state_nx = ST_THRU_GREEN;
                        w_timer_nx = '0;
                    end
                end
                ST_THRU_GREEN: begin
                    if ((r_timer >= c_gmin_last) &&
                        (!w_act_present || (r_timer >= c_gmax_last))) begin
                        w_state_nx = ST_THRU_YELLOW;
                        w_timer_nx = '0;
                    end
                end
                ST_THRU_YELLOW: begin
                    if (r_timer == c_yellow_last) begin
                        w_state_nx = ST_ALL_RED;
                        w_timer_nx = '0;
                    end
                end
                ST_FLASH: begin
                    w_state_nx = ST_ALL_RED;
                    w_timer_nx = '0;
                    w_scan0_nx = 1'b1;
                end
                default: begin
                    w_state_nx = ST_ALL_RED;
                    w_timer_nx = '0;
                end
            endcase
        end
    end

    assign w_enter_green = (w_state_nx == ST_THRU_GREEN) && (r_state != ST_THRU_GREEN);

    // Walk flag captured at green entry; pedestrian latch set/clear with clear winning.
    always_comb begin
        w_sel_nx = '0;
        for (int i = 0; i < NUM_APPR; i++) begin
            w_sel_nx[i] = (w_active_nx == 3'(i));
        end
        w_walk_nx  = r_walk;
        w_latch_nx = r_latch | ped_req;
        if (w_enter_green) begin
            w_walk_nx  = |((r_latch | ped_req) & w_sel_nx);
            w_latch_nx = w_latch_nx & ~w_sel_nx;
        end
    end

    // Light images for the cycle after the edge, so registered outputs track state.
    always_comb begin
        w_thru_nx = '0;
        w_left_nx = '0;
        w_ped_nx  = '0;
        for (int i = 0; i < NUM_APPR; i++) begin
            w_thru_nx[2*i +: 2] = c_light_red;
            w_left_nx[2*i +: 2] = c_light_red;
            w_ped_nx[2*i +: 2]  = c_ped_dont_walk;
            if (w_state_nx == ST_FLASH) begin
                w_thru_nx[2*i +: 2] = w_fyel_nx ? c_light_yellow : c_light_dark;
            end else if (w_sel_nx[i]) begin
                case (w_state_nx)
                    ST_LEFT_GREEN:  w_left_nx[2*i +: 2] = c_light_green;
                    ST_LEFT_YELLOW: w_left_nx[2*i +: 2] = c_light_yellow;
                    ST_THRU_GREEN: begin
                        w_thru_nx[2*i +: 2] = c_light_green;
                        if (w_walk_nx) begin
                            w_ped_nx[2*i +: 2] = (w_timer_nx < c_walk_len) ?
                                                 c_ped_walk : c_ped_flash_dont;
                        end
                    end
                    ST_THRU_YELLOW: begin
                        w_thru_nx[2*i +: 2] = c_light_yellow;
                        if (w_walk_nx) begin
                            w_ped_nx[2*i +: 2] = c_ped_flash_dont;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // FSM, timer, scan and latch state register.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_ALL_RED;
            r_timer  <= '0;
            r_active <= 3'd0;
            r_scan0  <= 1'b1;
            r_walk   <= 1'b0;
            r_fcnt   <= '0;
            r_fyel   <= 1'b1;
            r_latch  <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_timer  <= w_timer_nx;
            r_active <= w_active_nx;
            r_scan0  <= w_scan0_nx;
            r_walk   <= w_walk_nx;
            r_fcnt   <= w_fcnt_nx;
            r_fyel   <= w_fyel_nx;
            r_latch  <= w_latch_nx;
        end
    end

    // Registered light outputs.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_thru <= '0;
            r_left <= '0;
            r_ped  <= '0;
        end else begin
            r_thru <= w_thru_nx;
            r_left <= w_left_nx;
            r_ped  <= w_ped_nx;
        end
    end

    assign w_viol_en = (r_state != ST_FLASH);

    for (genvar g = 0; g < NUM_APPR; g++) begin : g_viol
        violation_monitor #(
            .VC_W (VC_W)
        ) u_viol (
            .i_clk          (CLK),
            .i_rst_n        (rst),
            .i_en           (w_viol_en),
            .i_thru_light   (r_thru[2*g +: 2]),
            .i_left_light   (r_left[2*g +: 2]),
            .i_leaving      (leaving[g]),
            .i_leaving_left (leaving_left[g]),
            .o_violation    (violation[g]),
            .o_count        (viol_count[VC_W*g +: VC_W])
        );
    end

    assign thru_light  = r_thru;
    assign left_light  = r_left;
    assign ped_light   = r_ped;
    assign state       = r_state;
    assign active_appr = r_active;

endmodule
`default_nettype wire

// File: tb/tb_intersection_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_intersection_controller
// Description : Scoreboard bench for intersection_controller. Stimulus pushes
//               cycle-tagged expectations and expected violation pulses; a
//               negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intersection_controller;

    localparam int N    = 4;
    localparam int VC_W = 4;

    logic            CLK = 1'b0;
    logic            rst = 1'b0;
    logic            flash_req = 1'b0;
    logic [N-1:0]    presence = '0;
    logic [N-1:0]    left_presence = '0;
    logic [N-1:0]    ped_req = '0;
    logic [N-1:0]    leaving = '0;
    logic [N-1:0]    leaving_left = '0;
    logic [2*N-1:0]  thru_light;
    logic [2*N-1:0]  left_light;
    logic [2*N-1:0]  ped_light;
    logic [2:0]      state;
    logic [2:0]      active_appr;
    logic [N-1:0]    violation;
    logic [VC_W*N-1:0] viol_count;

    intersection_controller dut (
        .CLK           (CLK),
        .rst           (rst),
        .flash_req     (flash_req),
        .presence      (presence),
        .left_presence (left_presence),
        .ped_req       (ped_req),
        .leaving       (leaving),
        .leaving_left  (leaving_left),
        .thru_light    (thru_light),
        .left_light    (left_light),
        .ped_light     (ped_light),
        .state         (state),
        .active_appr   (active_appr),
        .violation     (violation),
        .viol_count    (viol_count)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    localparam int S_STATE = 0, S_ACT = 1, S_THRU = 2, S_LEFT = 3,
                   S_PED = 4, S_VIOL = 5, S_VCNT = 6;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t         q[$];
    logic [N-1:0] vq[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic string sel_name(input int sel);
        case (sel)
            S_STATE: return "state";
            S_ACT:   return "active_appr";
            S_THRU:  return "thru_light";
            S_LEFT:  return "left_light";
            S_PED:   return "ped_light";
            S_VIOL:  return "violation";
            default: return "viol_count";
        endcase
    endfunction

    function automatic logic [31:0] sel_value(input int sel);
        case (sel)
            S_STATE: return 32'(state);
            S_ACT:   return 32'(active_appr);
            S_THRU:  return 32'(thru_light);
            S_LEFT:  return 32'(left_light);
            S_PED:   return 32'(ped_light);
            S_VIOL:  return 32'(violation);
            default: return 32'(viol_count);
        endcase
    endfunction

    task automatic exp_at(input int c, input int sel, input logic [31:0] v);
        exp_t e;
        e.cyc = c;
        e.sel = sel;
        e.exp = v;
        q.push_back(e);
    endtask

    // Advance to 1 ns after the edge that makes cyc == c.
    task automatic go(input int c);
        while (cyc < c) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Monitor: timed expectations plus event-driven violation pulses.
    always @(negedge CLK) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                check(sel_name(q[i].sel), sel_value(q[i].sel), q[i].exp);
                q.delete(i);
            end else if (q[i].cyc < cyc) begin
                check("missed_slot", 32'(q[i].cyc), 32'(cyc));
                q.delete(i);
            end
        end
        if (violation != '0) begin
            if (vq.size() == 0) begin
                check("unexpected_violation", 32'(violation), 32'd0);
            end else begin
                check("violation_pulse", 32'(violation), 32'(vq.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int c0, s, t, u, v, w;

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        rst      = 1'b1;
        presence = 4'b0100;
        c0       = cyc;
        // Reset values and a long-held through green on approach 2.
        exp_at(c0, S_STATE, 0);  exp_at(c0, S_ACT, 0);   exp_at(c0, S_THRU, 0);
        exp_at(c0, S_LEFT, 0);   exp_at(c0, S_PED, 0);   exp_at(c0, S_VIOL, 0);
        exp_at(c0, S_VCNT, 0);
        exp_at(c0 + 1,  S_STATE, 0);
        exp_at(c0 + 2,  S_STATE, 3); exp_at(c0 + 2, S_ACT, 2); exp_at(c0 + 2, S_THRU, 'h20);
        exp_at(c0 + 41, S_STATE, 3); exp_at(c0 + 41, S_THRU, 'h20);
        exp_at(c0 + 42, S_STATE, 4); exp_at(c0 + 42, S_THRU, 'h10);
        exp_at(c0 + 45, S_STATE, 4);
        exp_at(c0 + 46, S_STATE, 0); exp_at(c0 + 46, S_THRU, 0);
        go(c0 + 42);
        presence = '0;

        // Short presence pulse on approach 1: minimum green only.
        s = c0 + 50;
        go(s);
        exp_at(s + 1,  S_STATE, 3); exp_at(s + 1, S_ACT, 1); exp_at(s + 1, S_THRU, 'h08);
        exp_at(s + 5,  S_PED, 0);
        exp_at(s + 10, S_STATE, 3); exp_at(s + 10, S_THRU, 'h08);
        exp_at(s + 11, S_STATE, 4); exp_at(s + 11, S_THRU, 'h04);
        exp_at(s + 14, S_STATE, 4);
        exp_at(s + 15, S_STATE, 0); exp_at(s + 15, S_THRU, 0);
        exp_at(s + 20, S_STATE, 0);
        presence = 4'b0010;
        go(s + 3);
        presence = '0;

        // Protected left then through on approach 3.
        t = s + 25;
        go(t);
        exp_at(t + 1,  S_STATE, 1); exp_at(t + 1, S_ACT, 3);
        exp_at(t + 1,  S_LEFT, 'h80); exp_at(t + 1, S_THRU, 0);
        exp_at(t + 6,  S_STATE, 1); exp_at(t + 6, S_LEFT, 'h80);
        exp_at(t + 7,  S_STATE, 2); exp_at(t + 7, S_LEFT, 'h40);
        exp_at(t + 10, S_STATE, 2); exp_at(t + 10, S_LEFT, 'h40);
        exp_at(t + 11, S_STATE, 3); exp_at(t + 11, S_THRU, 'h80); exp_at(t + 11, S_LEFT, 0);
        exp_at(t + 20, S_STATE, 3);
        exp_at(t + 21, S_STATE, 4); exp_at(t + 21, S_THRU, 'h40);
        exp_at(t + 25, S_STATE, 0);
        presence      = 4'b1000;
        left_presence = 4'b1000;
        go(t + 1);
        presence      = '0;
        left_presence = '0;

        // Pedestrian request latched during approach 2 green, served on approach 0.
        u = t + 30;
        go(u);
        exp_at(u + 1,  S_STATE, 3); exp_at(u + 1, S_ACT, 2);
        exp_at(u + 5,  S_PED, 0);
        exp_at(u + 15, S_STATE, 0);
        exp_at(u + 16, S_STATE, 0);
        exp_at(u + 17, S_STATE, 3); exp_at(u + 17, S_ACT, 0);
        exp_at(u + 17, S_THRU, 'h02); exp_at(u + 17, S_PED, 'h02);
        exp_at(u + 22, S_PED, 'h02);
        exp_at(u + 23, S_PED, 'h01);
        exp_at(u + 26, S_STATE, 3); exp_at(u + 26, S_PED, 'h01);
        exp_at(u + 27, S_STATE, 4); exp_at(u + 27, S_PED, 'h01);
        exp_at(u + 30, S_PED, 'h01);
        exp_at(u + 31, S_STATE, 0); exp_at(u + 31, S_PED, 0);
        exp_at(u + 36, S_STATE, 0); exp_at(u + 36, S_ACT, 0);
        presence = 4'b0100;
        go(u + 3);
        presence = '0;
        ped_req  = 4'b0001;
        go(u + 4);
        ped_req  = '0;

        // Violations: saturation on approach 1, then a combined multi-approach event.
        v = u + 40;
        go(v);
        for (int k = 0; k < 20; k++) vq.push_back(4'b0010);
        vq.push_back(4'b1001);
        exp_at(v + 1,  S_VCNT, 'h0010);
        exp_at(v + 10, S_STATE, 0);
        exp_at(v + 14, S_VCNT, 'h00E0);
        exp_at(v + 15, S_VCNT, 'h00F0);
        exp_at(v + 20, S_VCNT, 'h00F0);
        exp_at(v + 21, S_VIOL, 0);
        exp_at(v + 26, S_VIOL, 'h9);
        exp_at(v + 26, S_VCNT, 'h10F1);
        leaving = 4'b0010;
        go(v + 20);
        leaving = '0;
        go(v + 25);
        leaving      = 4'b1001;
        leaving_left = 4'b1000;
        go(v + 26);
        leaving      = '0;
        leaving_left = '0;

        // Flash during through green, scan restart at 0, then async reset mid-green.
        w = v + 30;
        go(w);
        exp_at(w + 1,  S_STATE, 3); exp_at(w + 1, S_ACT, 2);
        exp_at(w + 3,  S_STATE, 3);
        exp_at(w + 4,  S_STATE, 5); exp_at(w + 4, S_THRU, 'h55);
        exp_at(w + 4,  S_LEFT, 0);  exp_at(w + 4, S_PED, 0);
        exp_at(w + 11, S_THRU, 'h55);
        exp_at(w + 12, S_THRU, 'hFF);
        exp_at(w + 19, S_THRU, 'hFF);
        exp_at(w + 20, S_THRU, 'h55);
        exp_at(w + 22, S_STATE, 0); exp_at(w + 22, S_THRU, 0);
        exp_at(w + 23, S_STATE, 0);
        exp_at(w + 24, S_STATE, 3); exp_at(w + 24, S_ACT, 0); exp_at(w + 24, S_THRU, 'h02);
        exp_at(w + 26, S_STATE, 0); exp_at(w + 26, S_THRU, 0); exp_at(w + 26, S_VCNT, 0);
        presence = 4'b0100;
        go(w + 3);
        presence  = '0;
        flash_req = 1'b1;
        go(w + 5);
        leaving_left = 4'b0001;
        go(w + 6);
        leaving_left = '0;
        go(w + 21);
        flash_req = 1'b0;
        presence  = 4'b1001;
        go(w + 26);
        rst      = 1'b0;
        presence = '0;
        go(w + 28);
        rst = 1'b1;
        go(w + 32);

        check("timed_queue_drained", 32'(q.size()), 32'd0);
        check("violation_queue_drained", 32'(vq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
